// File: rtl/tile_scheduler_if.sv
// rtl/tile_scheduler_if.sv - layer command and tile stream bundle for tile_scheduler
interface tile_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [1:0]       layer_type_i;
  logic [6:0]       out_R_i;
  logic [10:0]      in_D_i;
  logic [10:0]      out_K_i;
  logic [6:0]       tile_D_i;
  logic [6:0]       tile_K_i;
  logic [31:0]      tile_n_i;
  logic             tile_ready_i;
  logic             tile_valid_o;
  logic [6:0]       r_idx_o;
  logic [6:0]       r_len_o;
  logic [10:0]      k_idx_o;
  logic [6:0]       k_len_o;
  logic [10:0]      d_idx_o;
  logic [6:0]       d_len_o;
  logic             first_d_o;
  logic             last_d_o;
  logic             busy_o;
  logic             layer_done_o;
  logic [CNT_W-1:0] tile_count_o;

  // Controller side: issues layer commands and consumes tiles.
  modport master (
    output start_i, layer_type_i, out_R_i, in_D_i, out_K_i,
           tile_D_i, tile_K_i, tile_n_i, tile_ready_i,
    input  tile_valid_o, r_idx_o, r_len_o, k_idx_o, k_len_o,
           d_idx_o, d_len_o, first_d_o, last_d_o, busy_o,
           layer_done_o, tile_count_o
  );

  // Scheduler side.
  modport slave (
    input  start_i, layer_type_i, out_R_i, in_D_i, out_K_i,
           tile_D_i, tile_K_i, tile_n_i, tile_ready_i,
    output tile_valid_o, r_idx_o, r_len_o, k_idx_o, k_len_o,
           d_idx_o, d_len_o, first_d_o, last_d_o, busy_o,
           layer_done_o, tile_count_o
  );
endinterface

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - walks a conv/linear layer as (r, k, d) tiles, one per handshake
module tile_scheduler #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  tile_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state_q, state_d;

  // Captured layer fields; tile sizes are stored already made non-zero and clamped.
  logic [1:0]  type_q;
  logic [6:0]  out_r_q;
  logic [10:0] in_d_q;
  logic [10:0] out_k_q;
  logic [6:0]  tile_d_q;
  logic [6:0]  tile_k_q;
  logic [6:0]  tile_n_q;

  logic [6:0]       r_idx_q;
  logic [10:0]      k_idx_q;
  logic [10:0]      d_idx_q;
  logic [CNT_W-1:0] count_q;

  logic        start_acc;
  logic        zero_dim;
  logic [6:0]  tile_d_eff;
  logic [6:0]  tile_k_eff;
  logic [31:0] tile_n_nz;
  logic [6:0]  tile_n_eff;

  logic        is_dw;
  logic [10:0] r_rem, k_rem, d_rem;
  logic [6:0]  r_len, k_len, d_len_std;
  logic [7:0]  r_end;
  logic [11:0] k_end, d_end;
  logic        r_last, k_last, last_d_std;
  logic        first_d, last_d;
  logic        final_tile;
  logic        tile_valid;
  logic        hs;

  assign start_acc  = (state_q == IDLE) && bus.start_i;
  assign zero_dim   = (bus.out_R_i == 7'd0) || (bus.in_D_i == 11'd0) || (bus.out_K_i == 11'd0);
  assign tile_d_eff = (bus.tile_D_i == 7'd0) ? 7'd1 : bus.tile_D_i;
  assign tile_k_eff = (bus.tile_K_i == 7'd0) ? 7'd1 : bus.tile_K_i;
  assign tile_n_nz  = (bus.tile_n_i == 32'd0) ? 32'd1 : bus.tile_n_i;
  // Full 32-bit compare so a huge tile_n cannot alias to a small value when truncated.
  assign tile_n_eff = (tile_n_nz > {25'd0, bus.out_R_i}) ? bus.out_R_i : tile_n_nz[6:0];

  assign is_dw = (type_q == 2'd1);

  // Lengths are the tile size clipped to what remains of each dimension.
  assign r_rem     = {4'd0, out_r_q} - {4'd0, r_idx_q};
  assign k_rem     = out_k_q - k_idx_q;
  assign d_rem     = in_d_q - d_idx_q;
  assign r_len     = ({4'd0, tile_n_q} < r_rem) ? tile_n_q : r_rem[6:0];
  assign k_len     = ({4'd0, tile_k_q} < k_rem) ? tile_k_q : k_rem[6:0];
  assign d_len_std = ({4'd0, tile_d_q} < d_rem) ? tile_d_q : d_rem[6:0];

  assign r_end      = {1'b0, r_idx_q} + {1'b0, r_len};
  assign k_end      = {1'b0, k_idx_q} + {5'd0, k_len};
  assign d_end      = {1'b0, d_idx_q} + {5'd0, d_len_std};
  assign r_last     = r_end >= {1'b0, out_r_q};
  assign k_last     = k_end >= {1'b0, out_k_q};
  assign last_d_std = d_end >= {1'b0, in_d_q};

  // Depthwise layers have no reduction over input channels: every tile is a full pass.
  assign first_d    = is_dw || (d_idx_q == 11'd0);
  assign last_d     = is_dw || last_d_std;
  assign final_tile = last_d && k_last && r_last;

  assign hs = tile_valid && bus.tile_ready_i;

  // Capture layer fields on an accepted start; hold them for the whole layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q   <= 2'd0;
      out_r_q  <= 7'd0;
      in_d_q   <= 11'd0;
      out_k_q  <= 11'd0;
      tile_d_q <= 7'd0;
      tile_k_q <= 7'd0;
      tile_n_q <= 7'd0;
    end else if (start_acc) begin
      type_q   <= bus.layer_type_i;
      out_r_q  <= bus.out_R_i;
      in_d_q   <= bus.in_D_i;
      out_k_q  <= bus.out_K_i;
      tile_d_q <= tile_d_eff;
      tile_k_q <= tile_k_eff;
      tile_n_q <= tile_n_eff;
    end
  end

  // Tile cursor: d innermost, then k, then r; advances only on a non-final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_q <= 7'd0;
      k_idx_q <= 11'd0;
      d_idx_q <= 11'd0;
    end else if (start_acc) begin
      r_idx_q <= 7'd0;
      k_idx_q <= 11'd0;
      d_idx_q <= 11'd0;
    end else if (hs && !final_tile) begin
      if (!last_d) begin
        d_idx_q <= d_idx_q + {4'd0, tile_d_q};
      end else begin
        d_idx_q <= 11'd0;
        if (k_last) begin
          k_idx_q <= 11'd0;
          r_idx_q <= r_idx_q + tile_n_q;
        end else begin
          k_idx_q <= k_idx_q + {4'd0, tile_k_q};
        end
      end
    end
  end

  // Accepted-tile counter, cleared per layer and saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (start_acc) begin
      count_q <= '0;
    end else if (hs && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_d          = state_q;
    tile_valid       = 1'b0;
    bus.busy_o       = 1'b0;
    bus.layer_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = zero_dim ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        tile_valid = 1'b1;
        bus.busy_o = 1'b1;
        if (hs && final_tile) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.busy_o       = 1'b1;
        bus.layer_done_o = 1'b1;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload is forced to zero whenever no tile is offered.
  assign bus.tile_valid_o = tile_valid;
  assign bus.r_idx_o      = tile_valid ? r_idx_q : 7'd0;
  assign bus.r_len_o      = tile_valid ? r_len : 7'd0;
  assign bus.k_idx_o      = tile_valid ? k_idx_q : 11'd0;
  assign bus.k_len_o      = tile_valid ? k_len : 7'd0;
  assign bus.d_idx_o      = tile_valid ? (is_dw ? k_idx_q : d_idx_q) : 11'd0;
  assign bus.d_len_o      = tile_valid ? (is_dw ? k_len : d_len_std) : 7'd0;
  assign bus.first_d_o    = tile_valid && first_d;
  assign bus.last_d_o     = tile_valid && last_d;
  assign bus.tile_count_o = count_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - directed scoreboard bench for tile_scheduler
module tb_tile_scheduler;

  typedef struct packed {
    logic [6:0]  r;
    logic [6:0]  rl;
    logic [10:0] k;
    logic [6:0]  kl;
    logic [10:0] d;
    logic [6:0]  dl;
    logic        fd;
    logic        ld;
  } tile_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_scheduler_if #(.CNT_W(16)) bus ();

  tile_scheduler #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  tile_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tile_t mk(int r, int rl, int k, int kl, int d, int dl, int fd, int ld);
    tile_t t;
    t.r  = r[6:0];
    t.rl = rl[6:0];
    t.k  = k[10:0];
    t.kl = kl[6:0];
    t.d  = d[10:0];
    t.dl = dl[6:0];
    t.fd = fd[0];
    t.ld = ld[0];
    return t;
  endfunction

  function automatic tile_t dut_tile();
    return {bus.r_idx_o, bus.r_len_o, bus.k_idx_o, bus.k_len_o,
            bus.d_idx_o, bus.d_len_o, bus.first_d_o, bus.last_d_o};
  endfunction

  // Reference walk of a layer, pushing every expected tile in issue order.
  task automatic push_model(int typ, int R, int D, int K, int tD, int tK, int tn);
    int tne, tde, tke;
    tne = (tn == 0) ? 1 : tn;
    if (tne > R) tne = R;
    tde = (tD == 0) ? 1 : tD;
    tke = (tK == 0) ? 1 : tK;
    if (R == 0 || D == 0 || K == 0) return;
    for (int r = 0; r < R; r += tne) begin
      for (int k = 0; k < K; k += tke) begin
        int rl, kl;
        rl = (tne < R - r) ? tne : R - r;
        kl = (tke < K - k) ? tke : K - k;
        if (typ == 1) begin
          sb.push_back(mk(r, rl, k, kl, k, kl, 1, 1));
        end else begin
          for (int d = 0; d < D; d += tde) begin
            int dl;
            dl = (tde < D - d) ? tde : D - d;
            sb.push_back(mk(r, rl, k, kl, d, dl, (d == 0) ? 1 : 0, (d + dl >= D) ? 1 : 0));
          end
        end
      end
    end
  endtask

  task automatic push_req021();
    sb.push_back(mk(0, 4, 0, 32, 0, 32, 1, 0));
    sb.push_back(mk(0, 4, 0, 32, 32, 32, 0, 1));
    sb.push_back(mk(0, 4, 32, 32, 0, 32, 1, 0));
    sb.push_back(mk(0, 4, 32, 32, 32, 32, 0, 1));
  endtask

  // One-cycle start pulse; fields are scrambled afterwards to prove they were captured.
  task automatic start(int typ, int R, int D, int K, int tD, int tK, int tn);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.layer_type_i = typ[1:0];
    bus.out_R_i      = R[6:0];
    bus.in_D_i       = D[10:0];
    bus.out_K_i      = K[10:0];
    bus.tile_D_i     = tD[6:0];
    bus.tile_K_i     = tK[6:0];
    bus.tile_n_i     = tn;
    @(posedge clk);
    #1;
    bus.start_i      = 1'b0;
    bus.out_R_i      = 7'd3;
    bus.in_D_i       = 11'd1;
    bus.out_K_i      = 11'd2;
    bus.tile_D_i     = 7'd5;
    bus.tile_K_i     = 7'd9;
    bus.tile_n_i     = 32'd1;
  endtask

  // Accepts n_pop tiles, stalling stall_n cycles on tile index stall_at; optionally checks the done pulse.
  task automatic drain(int n_pop, int stall_at, int stall_n, int exp_cnt, bit check_done);
    int idx, st, cyc;
    tile_t exp;
    idx = 0;
    st  = 0;
    cyc = 0;
    while (idx < n_pop && cyc < 500) begin
      @(negedge clk);
      cyc++;
      chk("valid_hi", bus.tile_valid_o, 1'b1);
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
        break;
      end
      if (idx == stall_at && st < stall_n) begin
        bus.tile_ready_i = 1'b0;
        st++;
        chk("stall_hold", dut_tile(), sb[0]);
      end else begin
        bus.tile_ready_i = 1'b1;
        exp = sb.pop_front();
        chk("tile", dut_tile(), exp);
        idx++;
      end
    end
    if (idx < n_pop) chk("drain_timeout", idx, n_pop);
    if (check_done) begin
      @(negedge clk);
      chk("done_pulse", bus.layer_done_o, 1'b1);
      chk("done_valid_lo", bus.tile_valid_o, 1'b0);
      chk("done_busy", bus.busy_o, 1'b1);
      chk("tile_count", bus.tile_count_o, exp_cnt);
      @(negedge clk);
      chk("done_cleared", bus.layer_done_o, 1'b0);
      chk("idle_busy_lo", bus.busy_o, 1'b0);
      chk("idle_valid_lo", bus.tile_valid_o, 1'b0);
    end
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.layer_type_i = 2'd0;
    bus.out_R_i      = 7'd0;
    bus.in_D_i       = 11'd0;
    bus.out_K_i      = 11'd0;
    bus.tile_D_i     = 7'd0;
    bus.tile_K_i     = 7'd0;
    bus.tile_n_i     = 32'd0;
    bus.tile_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_valid", bus.tile_valid_o, 1'b0);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_done", bus.layer_done_o, 1'b0);
    chk("reset_payload", dut_tile(), '0);
    chk("reset_count", bus.tile_count_o, 0);
    rst_n = 1'b1;

    // Basic PW layer, ready held high.
    push_req021();
    start(0, 4, 64, 64, 32, 32, 4);
    drain(4, -1, 0, 4, 1'b1);

    // Remainder on d, tile_n of zero treated as one.
    sb.push_back(mk(0, 1, 0, 10, 0, 32, 1, 0));
    sb.push_back(mk(0, 1, 0, 10, 32, 8, 0, 1));
    start(0, 1, 40, 10, 32, 32, 0);
    drain(2, -1, 0, 2, 1'b1);

    // Depthwise: d follows k, both flags set.
    push_model(1, 5, 25, 25, 7, 10, 2);
    chk("dw_tile_total", sb.size(), 9);
    start(1, 5, 25, 25, 7, 10, 2);
    drain(9, -1, 0, 9, 1'b1);

    // Backpressure on the second tile for three cycles.
    push_req021();
    start(0, 4, 64, 64, 32, 32, 4);
    drain(4, 1, 3, 4, 1'b1);

    // STD with tile_n far above out_R (clamped).
    push_model(2, 3, 5, 7, 2, 3, 100);
    start(2, 3, 5, 7, 2, 3, 100);
    drain(9, -1, 0, 9, 1'b1);

    // LIN with all tile sizes zero.
    push_model(3, 2, 3, 2, 0, 0, 0);
    start(3, 2, 3, 2, 0, 0, 0);
    drain(12, -1, 0, 12, 1'b1);

    // Zero dimension: straight to DONE, no tiles, counter cleared.
    start(0, 4, 64, 0, 32, 32, 4);
    @(negedge clk);
    chk("zd_valid_lo", bus.tile_valid_o, 1'b0);
    chk("zd_done", bus.layer_done_o, 1'b1);
    chk("zd_busy", bus.busy_o, 1'b1);
    chk("zd_count", bus.tile_count_o, 0);
    @(negedge clk);
    chk("zd_done_lo", bus.layer_done_o, 1'b0);
    chk("zd_busy_lo", bus.busy_o, 1'b0);

    // Reset in the middle of a layer, then restart.
    push_req021();
    start(0, 4, 64, 64, 32, 32, 4);
    drain(2, -1, 0, 0, 1'b0);
    @(negedge clk);
    chk("mid_count", bus.tile_count_o, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.tile_valid_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.layer_done_o, 1'b0);
    chk("rst_payload", dut_tile(), '0);
    chk("rst_count", bus.tile_count_o, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.tile_valid_o, bus.busy_o}, 2'b00);
    end
    push_req021();
    start(0, 4, 64, 64, 32, 32, 4);
    drain(4, -1, 0, 4, 1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
